// File: rtl/sha256_job_arbiter.sv
// sha256_job_arbiter: round-robin scheduler sharing one simplified_sha256 core
// between N_REQ requesters, with a watchdog abort and a core reset after every job.
module sha256_job_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024,
    localparam int OW     = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [16*N_REQ-1:0]  msg_addr_i,
    input  logic [16*N_REQ-1:0]  out_addr_i,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     ack,
    output logic [N_REQ-1:0]     err,
    output logic                 busy,
    output logic [OW-1:0]        owner,
    output logic                 core_rst_n,
    output logic                 core_start,
    output logic [15:0]          core_message_addr,
    output logic [15:0]          core_output_addr,
    input  logic                 core_done
);
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, COMPLETE, ABORT} state_t;

    state_t           state, state_nxt;
    logic [OW-1:0]    rr_ptr, rr_nxt, owner_nxt, win, cand;
    logic [OW:0]      sum;
    logic [N_REQ-1:0] grant_nxt, ack_nxt, err_nxt;
    logic [15:0]      cnt, cnt_nxt, maddr_nxt, oaddr_nxt;
    logic             start_nxt, found;

    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        cand  = '0;
        // Scan from farthest to nearest so the first set bit after rr_ptr survives.
        for (int k = N_REQ; k >= 1; k--) begin
            sum  = {1'b0, rr_ptr} + (OW+1)'(k);
            cand = (sum >= (OW+1)'(N_REQ)) ? OW'(sum - (OW+1)'(N_REQ)) : OW'(sum);
            if (req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        state_nxt = state;
        rr_nxt    = rr_ptr;
        owner_nxt = owner;
        grant_nxt = grant;
        ack_nxt   = '0;
        err_nxt   = '0;
        start_nxt = 1'b0;
        cnt_nxt   = cnt;
        maddr_nxt = core_message_addr;
        oaddr_nxt = core_output_addr;
        case (state)
            IDLE: if (found) begin
                state_nxt = LAUNCH;
                rr_nxt    = win;
                owner_nxt = win;
                grant_nxt = N_REQ'(1) << win;
                start_nxt = 1'b1;
                maddr_nxt = msg_addr_i[{win, 4'b0000} +: 16];
                oaddr_nxt = out_addr_i[{win, 4'b0000} +: 16];
            end
            LAUNCH: begin
                cnt_nxt   = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                cnt_nxt = (cnt == 16'hffff) ? cnt : cnt + 16'd1;
                if (core_done) begin
                    state_nxt = COMPLETE;
                    ack_nxt   = grant;
                end else if (cnt == 16'(TIMEOUT-1)) begin
                    state_nxt = ABORT;
                    err_nxt   = grant;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            rr_ptr            <= OW'(N_REQ-1);
            owner             <= '0;
            grant             <= '0;
            ack               <= '0;
            err               <= '0;
            busy              <= 1'b0;
            core_rst_n        <= 1'b0;
            core_start        <= 1'b0;
            cnt               <= '0;
            core_message_addr <= '0;
            core_output_addr  <= '0;
        end else begin
            state             <= state_nxt;
            rr_ptr            <= rr_nxt;
            owner             <= owner_nxt;
            grant             <= grant_nxt;
            ack               <= ack_nxt;
            err               <= err_nxt;
            busy              <= state_nxt != IDLE;
            core_rst_n        <= state_nxt != COMPLETE && state_nxt != ABORT;
            core_start        <= start_nxt;
            cnt               <= cnt_nxt;
            core_message_addr <= maddr_nxt;
            core_output_addr  <= oaddr_nxt;
        end
    end
endmodule

// File: tb/tb_sha256_job_arbiter.sv
// tb_sha256_job_arbiter: randomized requesters and a latency-programmable core model,
// checked by a job-level scoreboard of expected launches and completions.
module tb_sha256_job_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0, reset_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [16*N-1:0] msg_addr_i = '0, out_addr_i = '0;
    logic [N-1:0]   grant, ack, err;
    logic           busy, core_rst_n, core_start, core_done;
    logic [1:0]     owner;
    logic [15:0]    core_message_addr, core_output_addr;

    sha256_job_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req(req),
        .msg_addr_i(msg_addr_i), .out_addr_i(out_addr_i),
        .grant(grant), .ack(ack), .err(err), .busy(busy), .owner(owner),
        .core_rst_n(core_rst_n), .core_start(core_start),
        .core_message_addr(core_message_addr), .core_output_addr(core_output_addr),
        .core_done(core_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        bit          is_err;
        logic [15:0] ma, oa;
        int          launch, fin;
    } job_t;

    job_t        q[$];
    job_t        e;
    int          vectors = 0, miscompares = 0, cyc;
    logic [N-1:0] rq = '0;
    logic [15:0] ma[N], oa[N];
    bit          m_busy = 0, hit;
    int          m_last = N-1, cur_own, cur_fin, cur_lat = 1;
    int          p_new, p_keep, p_wd, force_lat;
    logic [15:0] ccnt;

    // Core stand-in: done rises cur_lat cycles after start and stays until core reset.
    always @(posedge clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            core_done <= 1'b0;
            ccnt      <= '0;
        end else if (core_start) begin
            ccnt      <= 16'd1;
            core_done <= (cur_lat == 1);
        end else if (ccnt != 0) begin
            ccnt <= ccnt + 16'd1;
            if (int'(ccnt) + 1 == cur_lat) core_done <= 1'b1;
        end
    end

    always @(posedge clk or negedge reset_n)
        if (!reset_n) cyc <= 0;
        else cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: unexpected event (cycle %0d)", nm, cyc);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_grant"}, int'(grant), 0);
        chk({tag, "_ack"}, int'(ack), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_start"}, int'(core_start), 0);
        chk({tag, "_owner"}, int'(owner), 0);
        chk({tag, "_maddr"}, int'(core_message_addr), 0);
        chk({tag, "_oaddr"}, int'(core_output_addr), 0);
        chk({tag, "_core_rst_n"}, int'(core_rst_n), 0);
    endtask

    function automatic int pick_lat();
        case ($urandom_range(0, 4))
            0: return 1;
            1: return TO;
            2: return TO + 1;
            default: return int'($urandom_range(1, TO + 3));
        endcase
    endfunction

    // One cycle of requester behaviour plus the job-level reference model.
    task automatic step();
        int w, lat;
        job_t j;
        if (m_busy && cyc == cur_fin + 1) begin
            m_busy = 0;
            if ($urandom_range(0, 99) >= p_keep) rq[cur_own] = 1'b0;
        end
        for (int i = 0; i < N; i++)
            if (!rq[i] && !(m_busy && i == cur_own) && $urandom_range(0, 99) < p_new) rq[i] = 1'b1;
        if (m_busy && rq[cur_own] && $urandom_range(0, 99) < p_wd) rq[cur_own] = 1'b0;
        for (int i = 0; i < N; i++) begin
            ma[i] = 16'($urandom);
            oa[i] = 16'($urandom);
            msg_addr_i[16*i +: 16] = ma[i];
            out_addr_i[16*i +: 16] = oa[i];
        end
        if (!m_busy && rq != 0) begin
            w = -1;
            for (int k = 1; k <= N; k++)
                if (w < 0 && rq[(m_last + k) % N]) w = (m_last + k) % N;
            lat = (force_lat != 0) ? force_lat : pick_lat();
            j.idx    = w;
            j.is_err = lat > TO;
            j.ma     = ma[w];
            j.oa     = oa[w];
            j.launch = cyc + 1;
            j.fin    = j.launch + ((lat > TO) ? TO + 1 : lat + 1);
            q.push_back(j);
            m_busy  = 1;
            cur_own = w;
            cur_fin = j.fin;
            m_last  = w;
            cur_lat = lat;
        end
        req = rq;
    endtask

    task automatic drain();
        int n;
        p_new = 0; p_keep = 0; p_wd = 0;
        n = 0;
        while ((rq != 0 || m_busy) && n < 2000) begin
            @(negedge clk);
            step();
            n++;
        end
        if (rq != 0 || m_busy) fail("drain_timeout");
    endtask

    always @(negedge clk) begin
        if (reset_n && cyc != 0) begin
            if (core_start) begin
                if (q.size() == 0) fail("spurious_start");
                else begin
                    chk("launch_cycle", cyc, q[0].launch);
                    chk("launch_grant", int'(grant), 1 << q[0].idx);
                    chk("launch_owner", int'(owner), q[0].idx);
                    chk("launch_busy", int'(busy), 1);
                    chk("msg_addr", int'(core_message_addr), int'(q[0].ma));
                    chk("out_addr", int'(core_output_addr), int'(q[0].oa));
                end
            end
            if (ack != 0 || err != 0) begin
                if (q.size() == 0) fail("spurious_ack_err");
                else begin
                    e = q.pop_front();
                    chk("finish_cycle", cyc, e.fin);
                    chk("ack", int'(ack), e.is_err ? 0 : 1 << e.idx);
                    chk("err", int'(err), e.is_err ? 1 << e.idx : 0);
                    chk("finish_grant", int'(grant), 1 << e.idx);
                    chk("core_rst_pulse", int'(core_rst_n), 0);
                end
            end else if (!core_rst_n) fail("core_rst_n_stray");
        end
    end

    initial begin
        p_new = 20; p_keep = 30; p_wd = 3; force_lat = 0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        @(negedge clk);
        reset_n = 1'b1;
        step();
        @(negedge clk);
        chk("core_rst_n_release", int'(core_rst_n), 1);
        step();
        repeat (3000) begin
            @(negedge clk);
            step();
        end
        drain();
        p_new = 100; p_keep = 100; p_wd = 0; force_lat = 1000;
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            step();
            if (q.size() > 0 && cyc == q[0].launch + 10) hit = 1;
        end
        if (!hit) fail("midjob_reach");
        #2 reset_n = 1'b0;
        #1 check_reset("midjob");
        q.delete();
        m_busy = 0; m_last = N-1; force_lat = 3;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        step();
        repeat (60) begin
            @(negedge clk);
            step();
        end
        drain();
        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
